// File: rtl/pc_redirect_unit_if.sv
// rtl/pc_redirect_unit_if.sv - instruction beat and program-counter control bundle
// master is the fetch/counter side, slave is the redirect unit.
interface pc_redirect_unit_if;
  logic              InstrValid;
  logic              InstrReady;
  logic [15:0]       Instruction;
  logic [15:0]       InstrAddr;
  logic              Zero;
  logic [15:0]       LoadValue;
  logic              LoadEnable;
  logic signed [8:0] Offset;
  logic              OffsetEnable;

  modport master (
    output InstrValid, Instruction, InstrAddr, Zero,
    input  InstrReady, LoadValue, LoadEnable, Offset, OffsetEnable
  );

  modport slave (
    input  InstrValid, Instruction, InstrAddr, Zero,
    output InstrReady, LoadValue, LoadEnable, Offset, OffsetEnable
  );
endinterface

// File: rtl/pc_redirect_unit.sv
// rtl/pc_redirect_unit.sv - decodes fetched words and redirects the program counter
// Optional CALL/RET with link register when PCCTL_CALL_EN is defined.
module pc_redirect_unit (
  input  logic           Clock,
  input  logic           Reset,
  pc_redirect_unit_if.slave bus
);

  typedef enum logic [1:0] {
    DECODE   = 2'd0,
    TARGET   = 2'd1,
    REDIRECT = 2'd2,
    FLUSH    = 2'd3
  } state_t;

  localparam logic [3:0] OP_JMP  = 4'd8;
  localparam logic [3:0] OP_BR   = 4'd9;
  localparam logic [3:0] OP_BRZ  = 4'd10;
`ifdef PCCTL_CALL_EN
  localparam logic [3:0] OP_CALL = 4'd12;
  localparam logic [3:0] OP_RET  = 4'd13;
`endif

  state_t            state, next_state;
  logic              ready_q, ready_d;
  logic [15:0]       load_value_q, load_value_d;
  logic signed [8:0] offset_q, offset_d;
  logic              load_en_q, load_en_d;
  logic              off_en_q, off_en_d;

  logic [3:0] opcode;
  logic       fire;

  assign opcode = bus.Instruction[15:12];
  assign fire   = bus.InstrValid && ready_q;

`ifdef PCCTL_CALL_EN
  logic        is_call_q, is_call_d;
  logic [15:0] link_q, link_d;
  logic        unused_bits;
  assign unused_bits = ^bus.Instruction[11:9];
`else
  logic        unused_bits;
  assign unused_bits = ^{bus.Instruction[11:9], bus.InstrAddr};
`endif

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state <= DECODE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      DECODE: begin
        if (fire) begin
          case (opcode)
            OP_JMP:  next_state = TARGET;
            OP_BR:   next_state = REDIRECT;
            OP_BRZ:  if (bus.Zero) next_state = REDIRECT;
`ifdef PCCTL_CALL_EN
            OP_CALL: next_state = TARGET;
            OP_RET:  next_state = REDIRECT;
`endif
            default: next_state = DECODE;
          endcase
        end
      end
      TARGET:   if (fire) next_state = REDIRECT;
      REDIRECT: next_state = FLUSH;
      FLUSH:    if (fire) next_state = DECODE;
      default:  next_state = DECODE;
    endcase
  end

  // Next values of the registered outputs; enables are one-shot so they default low.
  always_comb begin
    load_value_d = load_value_q;
    offset_d     = offset_q;
    load_en_d    = 1'b0;
    off_en_d     = 1'b0;
    ready_d      = (next_state != REDIRECT);
`ifdef PCCTL_CALL_EN
    is_call_d    = is_call_q;
    link_d       = link_q;
`endif
    case (state)
      DECODE: begin
        if (fire) begin
          case (opcode)
            OP_BR: begin
              offset_d = bus.Instruction[8:0];
              off_en_d = 1'b1;
            end
            OP_BRZ: begin
              if (bus.Zero) begin
                offset_d = bus.Instruction[8:0];
                off_en_d = 1'b1;
              end
            end
`ifdef PCCTL_CALL_EN
            OP_JMP:  is_call_d = 1'b0;
            OP_CALL: is_call_d = 1'b1;
            OP_RET: begin
              load_value_d = link_q;
              load_en_d    = 1'b1;
            end
`endif
            default: ;
          endcase
        end
      end
      TARGET: begin
        if (fire) begin
          load_value_d = bus.Instruction;
          load_en_d    = 1'b1;
`ifdef PCCTL_CALL_EN
          if (is_call_q) link_d = bus.InstrAddr + 16'd1;
`endif
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      ready_q      <= 1'b0;
      load_value_q <= 16'd0;
      offset_q     <= 9'sd0;
      load_en_q    <= 1'b0;
      off_en_q     <= 1'b0;
`ifdef PCCTL_CALL_EN
      is_call_q    <= 1'b0;
      link_q       <= 16'd0;
`endif
    end else begin
      ready_q      <= ready_d;
      load_value_q <= load_value_d;
      offset_q     <= offset_d;
      load_en_q    <= load_en_d;
      off_en_q     <= off_en_d;
`ifdef PCCTL_CALL_EN
      is_call_q    <= is_call_d;
      link_q       <= link_d;
`endif
    end
  end

  assign bus.InstrReady   = ready_q;
  assign bus.LoadValue    = load_value_q;
  assign bus.LoadEnable   = load_en_q;
  assign bus.Offset       = offset_q;
  assign bus.OffsetEnable = off_en_q;

endmodule

// File: tb/tb_pc_redirect_unit.sv
// tb/tb_pc_redirect_unit.sv - directed self-checking bench for pc_redirect_unit
// Beat-level reference model plus hand-computed literal checks.
module tb_pc_redirect_unit;

  logic Clock;
  logic Reset;
  int   nvec = 0;
  int   nerr = 0;

  pc_redirect_unit_if bus ();

  pc_redirect_unit dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus.slave)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: tracks what the counter must see, one beat at a time.
  logic        m_ready, m_le, m_oe, m_want, m_drop, m_call;
  logic [15:0] m_lv, m_link;
  logic [8:0]  m_off;

  always @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      m_ready = 0; m_le = 0; m_oe = 0; m_want = 0; m_drop = 0; m_call = 0;
      m_lv = 0; m_link = 0; m_off = 0;
    end else begin
      logic fire, was_pulse;
      fire      = bus.InstrValid && m_ready;
      was_pulse = m_le || m_oe;
      m_le = 0;
      m_oe = 0;
      if (was_pulse) begin
        m_drop = 1;
      end else if (fire) begin
        if (m_drop) begin
          m_drop = 0;
        end else if (m_want) begin
          m_lv   = bus.Instruction;
          m_want = 0;
          m_le   = 1;
          if (m_call) m_link = bus.InstrAddr + 16'd1;
        end else begin
          case (bus.Instruction[15:12])
            4'd8:  begin m_want = 1; m_call = 0; end
            4'd9:  begin m_off = bus.Instruction[8:0]; m_oe = 1; end
            4'd10: if (bus.Zero) begin m_off = bus.Instruction[8:0]; m_oe = 1; end
`ifdef PCCTL_CALL_EN
            4'd12: begin m_want = 1; m_call = 1; end
            4'd13: begin m_lv = m_link; m_le = 1; end
`endif
            default: ;
          endcase
        end
      end
      m_ready = !(m_le || m_oe);
    end
  end

  always @(negedge Clock) begin
    check("ready", {15'd0, bus.InstrReady}, {15'd0, m_ready});
    check("load_en", {15'd0, bus.LoadEnable}, {15'd0, m_le});
    check("off_en", {15'd0, bus.OffsetEnable}, {15'd0, m_oe});
    check("load_value", bus.LoadValue, m_lv);
    check("offset", {7'd0, bus.Offset}, {7'd0, m_off});
    if (bus.LoadEnable && bus.OffsetEnable) check("both_en", 16'd1, 16'd0);
  end

  task automatic send(input logic [15:0] ins, input logic [15:0] addr, input logic z);
    bit done;
    done = 0;
    bus.InstrValid  = 1;
    bus.Instruction = ins;
    bus.InstrAddr   = addr;
    bus.Zero        = z;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge Clock);
      if (bus.InstrReady) done = 1;
      @(posedge Clock);
      #1;
    end
    if (!done) check("accept_timeout", 16'd0, 16'd1);
    bus.InstrValid = 0;
  endtask

  task automatic idle(input int n);
    bus.InstrValid = 0;
    repeat (n) begin
      @(posedge Clock);
      #1;
    end
  endtask

  // Sample the cycle right after an accept edge, then move to the next edge.
  task automatic expect_cycle(input string name, input logic le, input logic oe,
                              input logic [15:0] lv, input logic [8:0] off);
    @(negedge Clock);
    check({name, "_le"}, {15'd0, bus.LoadEnable}, {15'd0, le});
    check({name, "_oe"}, {15'd0, bus.OffsetEnable}, {15'd0, oe});
    if (le) check({name, "_lv"}, bus.LoadValue, lv);
    if (oe) check({name, "_off"}, {7'd0, bus.Offset}, {7'd0, off});
    if (le || oe) check({name, "_ready"}, {15'd0, bus.InstrReady}, 16'd0);
    @(posedge Clock);
    #1;
  endtask

  initial begin
    #200000;
    nerr++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    Reset           = 1;
    bus.InstrValid  = 0;
    bus.Instruction = 0;
    bus.InstrAddr   = 0;
    bus.Zero        = 0;
    #1 Reset = 0;
    repeat (2) @(negedge Clock);
    check("rst_ready", {15'd0, bus.InstrReady}, 16'd0);
    check("rst_lv", bus.LoadValue, 16'd0);
    @(posedge Clock);
    #1 Reset = 1;
    @(negedge Clock);
    check("rel_ready0", {15'd0, bus.InstrReady}, 16'd0);
    @(negedge Clock);
    check("rel_ready1", {15'd0, bus.InstrReady}, 16'd1);
    @(posedge Clock);
    #1;

    // BR +5, dropped in-flight beat, BR +5 again
    send(16'h9005, 16'h0010, 0);
    expect_cycle("br5", 0, 1, 16'd0, 9'h005);
    send(16'h9003, 16'h0011, 0);
    expect_cycle("dropped", 0, 0, 16'd0, 9'd0);
    send(16'h9005, 16'h0012, 0);
    expect_cycle("br5b", 0, 1, 16'd0, 9'h005);
    send(16'h0000, 16'h0013, 0);

    // BRZ -5 untaken then taken
    send(16'hA1FB, 16'h0020, 0);
    expect_cycle("brz_nt", 0, 0, 16'd0, 9'd0);
    send(16'hA1FB, 16'h0021, 1);
    expect_cycle("brz_t", 0, 1, 16'd0, 9'h1FB);
    send(16'h0000, 16'h0022, 0);

    // Self-loop and most-negative offset
    send(16'h9000, 16'h0030, 0);
    expect_cycle("br0", 0, 1, 16'd0, 9'h000);
    send(16'h0000, 16'h0031, 0);
    send(16'h9100, 16'h0032, 0);
    expect_cycle("br_m256", 0, 1, 16'd0, 9'h100);
    send(16'h0000, 16'h0033, 0);

    // JMP with a 3-cycle valid gap before the target
    send(16'h8000, 16'h0040, 0);
    idle(3);
    send(16'd2023, 16'h0041, 0);
    expect_cycle("jmp", 1, 0, 16'd2023, 9'd0);
    send(16'h0000, 16'h0042, 0);

    // Reset aborts a pending JMP target
    send(16'h8000, 16'h0050, 0);
    idle(1);
    Reset = 0;
    @(negedge Clock);
    check("abort_ready", {15'd0, bus.InstrReady}, 16'd0);
    check("abort_lv", bus.LoadValue, 16'd0);
    @(posedge Clock);
    #1 Reset = 1;
    @(posedge Clock);
    #1;
    send(16'd2023, 16'h0051, 0);
    expect_cycle("abort_tgt", 0, 0, 16'd0, 9'd0);

    // Reset during a pulse kills it; next beat decodes without a flush
    send(16'h9005, 16'h0060, 0);
    Reset = 0;
    @(negedge Clock);
    check("pulse_abort", {15'd0, bus.OffsetEnable}, 16'd0);
    @(posedge Clock);
    #1 Reset = 1;
    @(posedge Clock);
    #1;
    send(16'h9002, 16'h0061, 0);
    expect_cycle("post_abort", 0, 1, 16'd0, 9'h002);
    send(16'h0000, 16'h0062, 0);

    // CALL / RET with link wrap
    send(16'hC000, 16'hFFFE, 0);
    send(16'h0040, 16'hFFFF, 0);
`ifdef PCCTL_CALL_EN
    expect_cycle("call", 1, 0, 16'h0040, 9'd0);
    send(16'h0000, 16'h0000, 0);
    send(16'hD000, 16'h0040, 0);
    expect_cycle("ret", 1, 0, 16'h0000, 9'd0);
    send(16'h0000, 16'h0041, 0);
`else
    expect_cycle("call_off", 0, 0, 16'd0, 9'd0);
    send(16'hD000, 16'h0040, 0);
    expect_cycle("ret_off", 0, 0, 16'd0, 9'd0);
`endif
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/pc_redirect_unit.md
# pc_redirect_unit

Control-side partner of the program counter. Accepts fetched instruction words over a valid/ready beat interface, decodes control-flow opcodes, and drives the counter's LoadValue/LoadEnable/Offset/OffsetEnable inputs to redirect fetch. Sits between instruction memory read data and the program counter. Non-control-flow words pass without action, so the counter keeps incrementing.

## Interface
- No parameters; widths fixed at 16-bit address/instruction and 9-bit signed offset.
- Clock  in  1  sole clock, rising edge.
- Reset  in  1  asynchronous, active-low; low forces reset state immediately.
- InstrValid  in  1  Instruction/InstrAddr hold a fetched beat.
- InstrReady  out  1  unit accepts the beat this cycle; beat transfers when InstrValid && InstrReady at posedge.
- Instruction  in  16  fetched word.
- InstrAddr  in  16  address of the fetched word.
- Zero  in  1  datapath zero flag, sampled with the beat.
- LoadValue  out  16  absolute target to program counter.
- LoadEnable  out  1  one-cycle load pulse.
- Offset  out  9 signed  relative displacement to program counter.
- OffsetEnable  out  1  one-cycle offset pulse.

## Operation
- Opcode = Instruction[15:12]; 8 = JMP (two-word, second beat is target), 9 = BR (Offset = Instruction[8:0]), 10 = BRZ (BR only if Zero = 1), 12 = CALL, 13 = RET (CALL/RET only with the macro); all others = no action.
- States: DECODE, TARGET, REDIRECT, FLUSH.
- DECODE: InstrReady = 1. JMP/CALL beat -> TARGET. Taken BR/BRZ -> REDIRECT with Offset registered. Untaken BRZ or other opcode -> stay.
- TARGET: InstrReady = 1; next accepted beat's 16 bits become LoadValue -> REDIRECT. For CALL, link register <= InstrAddr of that beat + 1, modulo 2^16.
- REDIRECT: InstrReady = 0; exactly one of LoadEnable/OffsetEnable = 1 for one cycle -> FLUSH.
- FLUSH: InstrReady = 1; the first accepted beat, already in flight from the old path, is discarded without decode -> DECODE. Cycles without InstrValid wait in FLUSH.
- Offset is two's-complement; 9'h100 = -256 is legal. BR with offset 0 is taken (self-loop).
- LoadValue and Offset are held after the pulse until overwritten.
- Never asserts LoadEnable and OffsetEnable together.

## Timing
- Reset values: state DECODE, LoadValue 0, LoadEnable 0, Offset 0, OffsetEnable 0, link register 0. InstrReady is 0 while Reset is low and 1 from the first cycle after Reset deasserts.
- All outputs are registered; InstrReady decodes from state only.
- Latency: BR/BRZ beat accepted at edge N -> OffsetEnable high in cycle N+1. JMP second beat at edge N -> LoadEnable high in cycle N+1.
- Reset low in any state, including mid-TARGET or during a pulse, aborts immediately. The pending target is discarded and no pulse is emitted after release.
- InstrValid low in DECODE/TARGET stalls without state change.

## Configuration
- PCCTL_CALL_EN defined: opcode 12 behaves as JMP and records the link register. Opcode 13 (RET, single word) loads LoadValue <= link -> REDIRECT with a LoadEnable pulse.
- Undefined: no link register; opcodes 12 and 13 are no-action like any unused opcode.

## Test plan
- Reset low mid-run -> all outputs 0 and InstrReady 0 while low; InstrReady 1 one cycle after release.
- Beat 16'h9005 -> OffsetEnable pulse for one cycle with Offset = 5. InstrReady 0 that cycle; next beat dropped; following beat 16'h9005 decoded again.
- Beat 16'hA1FB with Zero = 0 -> no pulse. Same beat with Zero = 1 -> OffsetEnable pulse with Offset = -5 (9'h1FB).
- Beats 16'h8000, 16'd2023 with InstrValid gap of 3 cycles between them -> LoadEnable pulse with LoadValue = 2023 exactly one cycle after the second beat.
- 16'h8000 accepted, Reset pulsed low before target beat -> no LoadEnable. The subsequent beat 16'd2023 is treated as a no-action opcode.
- PCCTL_CALL_EN defined: 16'hC000 at InstrAddr 16'hFFFE, target 16'h0040 at InstrAddr 16'hFFFF -> LoadValue 16'h0040. Later RET 16'hD000 -> LoadValue 16'h0000 (link wrap). Without the macro -> no pulses.
